// File: rtl/i2c_overwrite_sched_pkg.sv
// Shared types and constants for the I2C overwrite rule scheduler.
package i2c_overwrite_sched_pkg;

  // Frame tracking states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_PASS  = 2'd2,
    ST_ARMED = 2'd3
  } state_e;

  // Byte framing: eight data bits counted down 8..1, then the ACK slot at 0.
  localparam int BITS_PER_BYTE = 9;
  localparam int ACK_SLOT      = 0;

  // Rule field widths.
  localparam int ADDR_W = 7;
  localparam int BYTE_W = 4;
  localparam int VAL_W  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [BYTE_W-1:0] byte_idx;
    logic [VAL_W-1:0]  value;
    logic              en;
    logic              oneshot;
  } rule_t;

endpackage

// File: rtl/i2c_overwrite_sched_rule_match.sv
// Combinational priority match of a captured address/RW byte against the rule table.
module i2c_rule_match
  import i2c_overwrite_sched_pkg::*;
#(
  parameter int NRULES = 4,
  parameter int IDXW   = 2
) (
  input  rule_t [NRULES-1:0] rules_i,
  input  logic  [7:0]        addr_byte_i,
  output logic               hit_o,
  output logic  [IDXW-1:0]   idx_o
);

  logic [NRULES-1:0] cand;

  // Per-rule candidate flags; byte index 0 marks a rule that can never fire.
  for (genvar g = 0; g < NRULES; g++) begin : g_cand
    assign cand[g] = rules_i[g].en
                  && (rules_i[g].addr == addr_byte_i[7:1])
                  && (rules_i[g].rw == addr_byte_i[0])
                  && (rules_i[g].byte_idx != '0);
  end

  // Scan from the top down so the lowest-index candidate is the one left standing.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NRULES - 1; i >= 0; i--) begin
      if (cand[i]) begin
        hit_o = 1'b1;
        idx_o = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/i2c_overwrite_sched.sv
// Rule-table scheduler choosing which frame/byte/value the bus-overwrite stage forces.
module i2c_overwrite_sched
  import i2c_overwrite_sched_pkg::*;
#(
  parameter int NRULES = 4,
  parameter int IDXW   = 2,
  parameter int CNTW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i2c_start,
  input  logic            i2c_stop,
  input  logic            i2c_data,
  input  logic            sda,
  input  logic            scl,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [6:0]      cfg_addr,
  input  logic            cfg_rw,
  input  logic [3:0]      cfg_byte,
  input  logic [7:0]      cfg_value,
  input  logic            cfg_en,
  input  logic            cfg_oneshot,
  output logic            out_0,
  output logic            out_1,
  output logic            active,
  output logic [IDXW-1:0] hit_idx,
  output logic [CNTW-1:0] hit_cnt,
  output logic            hit
);

  localparam logic [3:0] BIT_TOP = 4'(BITS_PER_BYTE - 1);
  localparam logic [3:0] BIT_ACK = 4'(ACK_SLOT);

  state_e                  state_q;
  logic [3:0]              bitcnt_q, bitcnt_d;
  logic [3:0]              bytecnt_q, bytecnt_d;
  logic [7:0]              addr_q;
  logic [IDXW-1:0]         sel_idx_q;
  logic [BYTE_W-1:0]       sel_byte_q;
  logic [VAL_W-1:0]        sel_val_q;
  rule_t [NRULES-1:0]      rules_q;
  logic [CNTW-1:0]         hit_cnt_q;
  logic                    hit_q, out0_q, out1_q;
  logic                    m_hit;
  logic [IDXW-1:0]         m_idx;
  logic                    frame_evt, ovr_done, en_ovr, drv_bit;
  logic [3:0]              bidx;

  i2c_rule_match #(.NRULES(NRULES), .IDXW(IDXW)) u_match (
    .rules_i    (rules_q),
    .addr_byte_i(addr_q),
    .hit_o      (m_hit),
    .idx_o      (m_idx)
  );

  assign frame_evt = i2c_start | i2c_stop;
  assign ovr_done  = (state_q == ST_ARMED) && i2c_data && !frame_evt
                  && (bitcnt_q == 4'd1) && (bytecnt_q == sel_byte_q);
  assign en_ovr    = (state_q == ST_ARMED) && (bytecnt_q == sel_byte_q) && (bitcnt_q != BIT_ACK);
  assign bidx      = bitcnt_q - 4'd1;
  assign drv_bit   = sel_val_q[bidx[2:0]];

  // Bit/byte framing: start or stop rewinds, each data strobe steps the bit slot.
  always_comb begin
    bitcnt_d  = bitcnt_q;
    bytecnt_d = bytecnt_q;
    if (frame_evt) begin
      bitcnt_d  = BIT_TOP;
      bytecnt_d = '0;
    end else if (i2c_data) begin
      if (bitcnt_q == BIT_ACK) begin
        bitcnt_d = BIT_TOP;
        if (bytecnt_q != 4'hF) bytecnt_d = bytecnt_q + 4'd1;
      end else begin
        bitcnt_d = bitcnt_q - 4'd1;
      end
    end
  end

  // Frame counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt_q  <= BIT_TOP;
      bytecnt_q <= '0;
    end else begin
      bitcnt_q  <= bitcnt_d;
      bytecnt_q <= bytecnt_d;
    end
  end

  // Frame FSM: capture address, latch the winning rule, count completed overwrites.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      sel_idx_q  <= '0;
      sel_byte_q <= '0;
      sel_val_q  <= '0;
      hit_cnt_q  <= '0;
      hit_q      <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (i2c_start) begin
        state_q <= ST_ADDR;
      end else if (i2c_stop) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_ADDR: begin
            if (i2c_data) begin
              if (bitcnt_q != BIT_ACK) begin
                addr_q <= {addr_q[6:0], sda};
              end else if (m_hit) begin
                sel_idx_q  <= m_idx;
                sel_byte_q <= rules_q[m_idx].byte_idx;
                sel_val_q  <= rules_q[m_idx].value;
                state_q    <= ST_ARMED;
              end else begin
                state_q <= ST_PASS;
              end
            end
          end
          ST_ARMED: begin
            if (ovr_done) begin
              hit_q   <= 1'b1;
              state_q <= ST_PASS;
              if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNTW'(1);
            end
          end
          ST_PASS: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Rule table; a host write lands after a same-cycle oneshot clear so the write wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rules_q <= '0;
    end else begin
      if (ovr_done && rules_q[sel_idx_q].oneshot) rules_q[sel_idx_q].en <= 1'b0;
      if (cfg_we) begin
        rules_q[cfg_idx] <= '{addr: cfg_addr, rw: cfg_rw, byte_idx: cfg_byte,
                              value: cfg_value, en: cfg_en, oneshot: cfg_oneshot};
      end
    end
  end

  // Drive register: cleared on frame boundaries, otherwise only updated while scl is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out0_q <= 1'b0;
      out1_q <= 1'b0;
    end else if (frame_evt) begin
      out0_q <= 1'b0;
      out1_q <= 1'b0;
    end else if (!scl) begin
      out0_q <= en_ovr && !drv_bit;
      out1_q <= en_ovr && drv_bit;
    end
  end

  assign out_0   = out0_q;
  assign out_1   = out1_q;
  assign active  = (state_q == ST_ARMED);
  assign hit_idx = sel_idx_q;
  assign hit_cnt = hit_cnt_q;
  assign hit     = hit_q;

endmodule

// File: doc/i2c_overwrite_sched.md
Name: i2c_overwrite_sched

Overview:
Rule-table scheduler that decides which I2C frame, which data byte and which value the bus-overwrite drive stage forces. It tracks frame progress from the I2C PHY event strobes (start, stop, per-bit data) and captures the address/RW byte. It then selects one matching rule from a host-programmable table and drives the out_0/out_1 force-low/force-high enables for that byte only. It sits between the I2CPhy instance and the open-drain pad drivers, and replaces a hard-coded target/value pair with a configurable one.

Parameters:
NRULES, 4, number of rule entries (power of two, 2..16)
IDXW, 2, log2(NRULES)
CNTW, 8, width of saturating hit counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
i2c_start  in  1  PHY start/repeated-start strobe, 1 clk
i2c_stop  in  1  PHY stop strobe, 1 clk
i2c_data  in  1  PHY bit-sample strobe, 1 clk; sda is valid in the same cycle
sda  in  1  bus data level
scl  in  1  bus clock level
cfg_we  in  1  rule write strobe
cfg_idx  in  IDXW  rule index to write
cfg_addr  in  7  rule target address
cfg_rw  in  1  rule RW match value
cfg_byte  in  4  data-byte index to overwrite (1 = first byte after address; 0 = rule never fires)
cfg_value  in  8  overwrite value, MSB first
cfg_en  in  1  rule enable
cfg_oneshot  in  1  clear enable after first completed overwrite
out_0  out  1  force bus low
out_1  out  1  release/force high
active  out  1  a rule is selected for the current frame
hit_idx  out  IDXW  index of selected rule
hit_cnt  out  CNTW  completed overwrites, saturating
hit  out  1  1-clk pulse on completed overwrite

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM IDLE; rule enables cleared; bitcnt=8, bytecnt=0.
- Bit framing: 9 bits per byte, bitcnt counts 8..0; bitcnt=0 is the ACK slot. On each i2c_data: bitcnt 0 -> 8 and bytecnt+1 (saturate at 15), else bitcnt-1.
- FSM states: IDLE, ADDR, PASS, ARMED.
- IDLE: wait for i2c_start -> ADDR.
- ADDR: shift sda into the 8-bit address register on bits 8..1. On the i2c_data strobe with bitcnt=0, evaluate the table: the lowest-index rule with en=1, addr==captured[7:1], rw==captured[0] and cfg_byte!=0 wins. A hit latches sel idx/byte/value and goes to ARMED. No hit goes to PASS.
- ARMED: en_ovr = (bytecnt==sel_byte) && (bitcnt!=0). Drive bit = sel_value[bitcnt-1]. The ACK slot is never driven.
- When the i2c_data strobe samples bitcnt=1 of the selected byte, the overwrite is complete: pulse hit, increment hit_cnt (saturating at all-ones), clear the rule enable if oneshot, then go to PASS.
- PASS: no driving until stop/start.
- Latched selection is immune to cfg writes during the frame. Table writes take effect from the next cycle.
- i2c_start in any state: restart the frame (bitcnt=8, bytecnt=0, ADDR), drop selection, active=0. Start has priority over a same-cycle i2c_data. Repeated start re-evaluates rules.
- i2c_stop in any state: go to IDLE, drop selection.
- On the same cycle as start or stop, out_0/out_1 are cleared regardless of scl.
- Output register: otherwise, only when scl==0: out_0 <= en_ovr && !bit, out_1 <= en_ovr && bit. While scl==1, out_0/out_1 hold.
- active=1 exactly in ARMED; hit_idx holds the last selected index.
- cfg_we to the same index as a same-cycle oneshot clear: the cfg write wins.
- Reset mid-frame: everything returns to reset values immediately, including both outputs.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE/ADDR/PASS/ARMED).
  - Byte framing constants (BITS_PER_BYTE=9, ACK_SLOT=0).
  - Rule field widths (ADDR_W=7, BYTE_W=4, VAL_W=8).
- One sub-module, i2c_rule_match: combinational priority match over the table, returning hit flag plus index.
- Frame counters, FSM and output register stay in i2c_overwrite_sched.

Test Plan:
- Rule0 = {0x50, rw=1, byte=1, 0x55, en}; frame start, addr byte 0xA1, ACK, 9 data bits with scl toggling -> during byte1 bits 8..1 out_0/out_1 follow 0,1,0,1,0,1,0,1. Both are 0 in the ACK slot. hit pulses once, hit_cnt=1, hit_idx=0.
- Same rule, addr byte 0xA0 (write) -> active=0, out_0=out_1=0 for the whole frame, hit_cnt unchanged.
- Rule1 and rule2 both match 0x50 read, rule2 byte=2 value 0xF0 -> rule1 selected (hit_idx=1). Disable rule1 and repeat -> byte2 driven 1,1,1,1,0,0,0,0; byte1 not driven.
- Rule0 oneshot=1, two consecutive 0x50 read frames -> first frame overwritten, enable cleared; second frame not overwritten, hit_cnt=1.
- i2c_stop asserted mid byte1 with scl=1 and out_1=1 -> out_1=0 next clk, FSM IDLE. Repeated start mid byte1 -> re-match on new address.
- rst driven low mid-overwrite -> outputs 0 asynchronously, table disabled; after release, a 0x50 read frame is not overwritten.
